// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receive framing blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        CP    = 3'd2,
        DATA  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } cprm_state_t;

    // Configuration latch contents before the first capture.
    localparam int NFFT_DEF = 4096;
    localparam int CP_DEF   = 256;

    // Packed I/Q sample layout.
    localparam int I_LSB = 0;
    localparam int I_MSB = 15;
    localparam int Q_LSB = 16;
    localparam int Q_MSB = 31;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready skid buffer carrying an opaque W-bit payload.
// Latency: 1 cycle from input acceptance to m_vld.
// Backpressure: s_rdy is the not-full flag, derived from registers only, so no combinational path from m_rdy.
// Ports: s_vld/s_rdy/s_dat input side, m_vld/m_rdy/m_dat output side,
//        drained = empty now or emptying at this clock edge.
module axis_skid_buf #(
    parameter int W = 34
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         s_vld,
    output logic         s_rdy,
    input  logic [W-1:0] s_dat,
    output logic         m_vld,
    input  logic         m_rdy,
    output logic [W-1:0] m_dat,
    output logic         drained
);

    logic [W-1:0] ent0_q, ent1_q;
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         push, pop;

    assign s_rdy   = (count_q != 2'd2);
    assign m_vld   = (count_q != 2'd0);
    // The head entry is never the write target while occupied, so m_dat
    // holds steady for as long as the beat is stalled.
    assign m_dat   = rd_ptr_q ? ent1_q : ent0_q;
    assign push    = s_vld && s_rdy;
    assign pop     = m_vld && m_rdy;
    assign drained = (count_q == 2'd0) || ((count_q == 2'd1) && m_rdy);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) ent1_q <= s_dat;
                else          ent0_q <= s_dat;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ofdm_cp_remover.sv
// Receive OFDM framer: drops a start offset, then per symbol drops the CP and forwards nfft samples with tuser/tlast.
// Latency: 1 cycle from input acceptance to m_axis_tvalid (through the skid buffer).
// Backpressure: SKIP/CP always ready; DATA ready = registered skid not-full; DRAIN/DONE not ready.
// Ports: aclk/areset; i_start + i_nfft/i_cp_len/i_skip/i_num_symbols config;
//        s_axis_* from the DDC, m_axis_* to the FFT; o_busy/o_done/o_sym_count status.
module ofdm_cp_remover
    import ofdm_rx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NFFT_W = 13,
    parameter int CP_W   = 11,
    parameter int SKIP_W = 16,
    parameter int SYM_W  = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              i_start,
    input  logic [NFFT_W-1:0] i_nfft,
    input  logic [CP_W-1:0]   i_cp_len,
    input  logic [SKIP_W-1:0] i_skip,
    input  logic [SYM_W-1:0]  i_num_symbols,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              o_busy,
    output logic              o_done,
    output logic [SYM_W-1:0]  o_sym_count
);

    cprm_state_t       state_q, state_d;
    // One beat counter serves skip, CP and sample phases; it is wide enough
    // for any of them and is cleared on every phase change.
    logic [SKIP_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0]  sym_idx_q, sym_idx_d;
    logic [SYM_W-1:0]  sym_count_q;
    logic [NFFT_W-1:0] nfft_q;
    logic [CP_W-1:0]   cp_q;
    logic [SKIP_W-1:0] skip_q;
    logic [SYM_W-1:0]  nsym_q;
    logic              cfg_load;

    logic              acc;
    logic              buf_in_vld, buf_in_rdy, buf_drained;
    logic              in_user, in_last;
    logic              is_last_sample, is_last_sym;

    assign acc            = s_axis_tvalid && s_axis_tready;
    assign is_last_sample = (cnt_q == SKIP_W'(nfft_q) - SKIP_W'(1));
    assign is_last_sym    = (sym_idx_q == nsym_q - SYM_W'(1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sym_idx_d     = sym_idx_q;
        cfg_load      = 1'b0;
        s_axis_tready = 1'b0;
        buf_in_vld    = 1'b0;
        in_user       = 1'b0;
        in_last       = 1'b0;
        case (state_q)
            IDLE: begin
                s_axis_tready = !areset;
                if (i_start) begin
                    cfg_load  = 1'b1;
                    cnt_d     = '0;
                    sym_idx_d = '0;
                    if (i_nfft == '0 || i_num_symbols == '0) state_d = DONE;
                    else if (i_skip != '0)                   state_d = SKIP;
                    else if (i_cp_len != '0)                 state_d = CP;
                    else                                     state_d = DATA;
                end
            end
            SKIP: begin
                s_axis_tready = 1'b1;
                if (acc) begin
                    if (cnt_q == skip_q - SKIP_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (cp_q != '0) ? CP : DATA;
                    end else begin
                        cnt_d = cnt_q + SKIP_W'(1);
                    end
                end
            end
            CP: begin
                s_axis_tready = 1'b1;
                if (acc) begin
                    if (cnt_q == SKIP_W'(cp_q) - SKIP_W'(1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + SKIP_W'(1);
                    end
                end
            end
            DATA: begin
                s_axis_tready = buf_in_rdy;
                buf_in_vld    = s_axis_tvalid;
                in_user       = (cnt_q == '0);
                in_last       = is_last_sample;
                if (acc) begin
                    if (is_last_sample) begin
                        cnt_d     = '0;
                        sym_idx_d = sym_idx_q + SYM_W'(1);
                        if (is_last_sym)       state_d = DRAIN;
                        else if (cp_q != '0)   state_d = CP;
                        else                   state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + SKIP_W'(1);
                    end
                end
            end
            // Leave as the final beat is taken so o_done follows it by one cycle.
            DRAIN: if (buf_drained) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sym_idx_q   <= '0;
            sym_count_q <= '0;
            nfft_q      <= NFFT_W'(NFFT_DEF);
            cp_q        <= CP_W'(CP_DEF);
            skip_q      <= '0;
            nsym_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sym_idx_q <= sym_idx_d;
            if (cfg_load) begin
                nfft_q      <= i_nfft;
                cp_q        <= i_cp_len;
                skip_q      <= i_skip;
                nsym_q      <= i_num_symbols;
                sym_count_q <= '0;
            end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                sym_count_q <= sym_count_q + SYM_W'(1);
            end
        end
    end

    axis_skid_buf #(
        .W(DATA_W + 2)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_vld   (buf_in_vld),
        .s_rdy   (buf_in_rdy),
        .s_dat   ({in_user, in_last, s_axis_tdata}),
        .m_vld   (m_axis_tvalid),
        .m_rdy   (m_axis_tready),
        .m_dat   ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
        .drained (buf_drained)
    );

    assign o_busy      = (state_q == SKIP) || (state_q == CP) ||
                         (state_q == DATA) || (state_q == DRAIN);
    assign o_done      = (state_q == DONE);
    assign o_sym_count = sym_count_q;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Self-checking bench for ofdm_cp_remover against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: randomised on both the source and sink sides.
module tb_ofdm_cp_remover;

    logic        aclk = 1'b0;
    logic        areset;
    logic        i_start;
    logic [12:0] i_nfft;
    logic [10:0] i_cp_len;
    logic [15:0] i_skip;
    logic [7:0]  i_num_symbols;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_sym_count;

    ofdm_cp_remover dut (
        .aclk          (aclk),
        .areset        (areset),
        .i_start       (i_start),
        .i_nfft        (i_nfft),
        .i_cp_len      (i_cp_len),
        .i_skip        (i_skip),
        .i_num_symbols (i_num_symbols),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_sym_count   (o_sym_count)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Beats are {tuser, tlast, tdata}.
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];
    int done_iter, last_acc_iter, stall_viol, done_pulses;
    logic busy_at_done, busy_before_done, busy_iter1;

    // Reference: the input stream counts 0,1,2,... over accepted beats, so the
    // k-th kept sample of symbol s is simply its position in that stream.
    function automatic void build_exp(input int nfft, input int cp, input int skip, input int nsym);
        exp_q.delete();
        for (int s = 0; s < nsym; s++)
            for (int k = 0; k < nfft; k++)
                exp_q.push_back({(k == 0), (k == nfft - 1), 32'(skip + s * (cp + nfft) + cp + k)});
    endfunction

    function automatic int stream_errs(output int first_idx);
        int errs = 0;
        first_idx = 0;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            if (got_q[k] !== exp_q[k]) begin
                if (errs == 0) first_idx = k;
                errs++;
            end
        return errs;
    endfunction

    // Drives one capture cycle by cycle from negedge to negedge; outputs are
    // sampled 1 time unit after each negedge, i.e. well before the next posedge.
    task automatic run_frame(input int nfft, input int cp, input int skip, input int nsym,
                             input int vld_pct, input int rdy_pct,
                             input int restart_iter, input int abort_iter, input int budget);
        logic [33:0] held = '0;
        logic        stalled = 1'b0;
        logic        prev_busy = 1'b0;
        logic        s_acc;
        logic [31:0] src = '0;
        got_q.delete();
        done_iter = -1; last_acc_iter = -1; stall_viol = 0; done_pulses = 0;
        busy_at_done = 1'b0; busy_before_done = 1'b0; busy_iter1 = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (i == abort_iter) return;
            if (i == 0) begin
                i_start = 1'b1;
                i_nfft = 13'(nfft); i_cp_len = 11'(cp); i_skip = 16'(skip); i_num_symbols = 8'(nsym);
                s_axis_tvalid = 1'b0;
            end else begin
                // Config inputs wander after start; only the latched copy may matter.
                i_start = (i == restart_iter);
                i_nfft = 13'($urandom); i_cp_len = 11'($urandom);
                i_skip = 16'($urandom); i_num_symbols = 8'($urandom);
                s_axis_tvalid = ($urandom_range(99) < vld_pct);
            end
            s_axis_tdata  = src;
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            #1;
            if (o_done) begin
                done_pulses++;
                if (done_iter < 0) begin
                    done_iter = i; busy_at_done = o_busy; busy_before_done = prev_busy;
                end
            end
            if (i == 1) busy_iter1 = o_busy;
            prev_busy = o_busy;
            if (stalled && ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {1'b1, held}))
                stall_viol++;
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
                last_acc_iter = i;
            end
            s_acc = s_axis_tvalid && s_axis_tready;
            @(negedge aclk);
            if (s_acc) src++;
            if (done_iter >= 0 && i >= done_iter + 3) break;
        end
        i_start = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        if (abort_iter < 0) begin
            n_cmp++;
            if (done_iter < 0) begin
                n_bad++;
                $display("FAIL frame_timeout: o_done not seen within %0d cycles, got %0d beats need %0d",
                         budget, got_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; i_start = 1'b0; i_nfft = '0; i_cp_len = '0; i_skip = '0; i_num_symbols = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        @(negedge aclk); @(negedge aclk); #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b need 0", s_axis_tready); end
        n_cmp++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin n_bad++; $display("FAIL rst_mflags: got %b need 000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser}); end
        n_cmp++; if (m_axis_tdata !== 32'd0) begin n_bad++; $display("FAIL rst_tdata: got %h need 0", m_axis_tdata); end
        n_cmp++; if ({o_busy, o_done} !== 2'b00) begin n_bad++; $display("FAIL rst_status: got %b need 00", {o_busy, o_done}); end
        n_cmp++; if (o_sym_count !== 8'd0) begin n_bad++; $display("FAIL rst_symcnt: got %0d need 0", o_sym_count); end
        @(negedge aclk); areset = 1'b0; #1;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL idle_tready: got %b need 1", s_axis_tready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL idle_drop: got tvalid %b need 0", m_axis_tvalid); end
        @(negedge aclk); s_axis_tvalid = 1'b0;
    endtask

    task automatic test_nominal();
        int first, errs;
        build_exp(4096, 256, 0, 2);
        run_frame(4096, 256, 0, 2, 100, 100, -1, -1, 12000);
        errs = stream_errs(first);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL nominal_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL nominal_stream: %0d bad, first #%0d got %h need %h", errs, first, got_q[first], exp_q[first]); end
        n_cmp++; if (o_sym_count !== 8'd2) begin n_bad++; $display("FAIL nominal_symcnt: got %0d need 2", o_sym_count); end
        n_cmp++; if (done_iter - last_acc_iter !== 1) begin n_bad++; $display("FAIL nominal_done_lat: got %0d need 1", done_iter - last_acc_iter); end
        n_cmp++; if (done_pulses !== 1) begin n_bad++; $display("FAIL nominal_done_pulses: got %0d need 1", done_pulses); end
    endtask

    task automatic test_small_offset();
        int first, errs;
        build_exp(8, 2, 3, 3);
        run_frame(8, 2, 3, 3, 100, 100, -1, -1, 200);
        errs = stream_errs(first);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL small_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL small_stream: %0d bad, first #%0d got %h need %h", errs, first, got_q[first], exp_q[first]); end
        n_cmp++; if (busy_iter1 !== 1'b1) begin n_bad++; $display("FAIL small_busy_rise: got %b need 1", busy_iter1); end
        n_cmp++; if ({busy_before_done, busy_at_done} !== 2'b10) begin n_bad++; $display("FAIL small_busy_fall: got %b need 10", {busy_before_done, busy_at_done}); end
        n_cmp++; if (o_sym_count !== 8'd3) begin n_bad++; $display("FAIL small_symcnt: got %0d need 3", o_sym_count); end
    endtask

    task automatic test_backpressure();
        int first, errs;
        build_exp(4096, 256, 0, 2);
        run_frame(4096, 256, 0, 2, 70, 50, -1, -1, 40000);
        errs = stream_errs(first);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL bp_stream: %0d bad, first #%0d got %h need %h", errs, first, got_q[first], exp_q[first]); end
        n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled need 0", stall_viol); end
        n_cmp++; if (done_iter - last_acc_iter !== 1) begin n_bad++; $display("FAIL bp_done_lat: got %0d need 1", done_iter - last_acc_iter); end
    endtask

    task automatic test_degenerate();
        int first, errs;
        build_exp(8, 2, 0, 0);
        run_frame(8, 2, 0, 0, 100, 100, -1, -1, 50);
        n_cmp++; if (done_iter !== 1) begin n_bad++; $display("FAIL nsym0_done: got cycle %0d need 1", done_iter); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL nsym0_beats: got %0d need 0", got_q.size()); end
        build_exp(1, 0, 0, 20);
        run_frame(1, 0, 0, 20, 60, 70, -1, -1, 400);
        errs = stream_errs(first);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL nfft1_count: got %0d beats need %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL nfft1_stream: %0d bad, first #%0d got %h need %h", errs, first, got_q[first], exp_q[first]); end
        n_cmp++; if (o_sym_count !== 8'd20) begin n_bad++; $display("FAIL nfft1_symcnt: got %0d need 20", o_sym_count); end
    endtask

    task automatic test_start_ignored();
        int first, errs;
        build_exp(8, 2, 3, 3);
        run_frame(8, 2, 3, 3, 100, 100, 10, -1, 200);
        errs = stream_errs(first);
        n_cmp++; if (errs !== 0 || got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL restart_stream: %0d bad, got %0d beats need %0d", errs, got_q.size(), exp_q.size()); end
        n_cmp++; if (o_sym_count !== 8'd3) begin n_bad++; $display("FAIL restart_symcnt: got %0d need 3", o_sym_count); end
        n_cmp++; if (done_pulses !== 1) begin n_bad++; $display("FAIL restart_done_pulses: got %0d need 1", done_pulses); end
    endtask

    task automatic test_reset_mid();
        int first, errs;
        build_exp(8, 2, 3, 3);
        run_frame(8, 2, 3, 3, 100, 100, -1, 19, 200);
        n_cmp++; if (o_sym_count !== 8'd1) begin n_bad++; $display("FAIL midrst_pre_symcnt: got %0d need 1", o_sym_count); end
        areset = 1'b1; #1;
        n_cmp++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000 || m_axis_tdata !== 32'd0) begin n_bad++; $display("FAIL midrst_mout: got %b/%h need 000/0", {m_axis_tvalid, m_axis_tlast, m_axis_tuser}, m_axis_tdata); end
        n_cmp++; if ({s_axis_tready, o_busy, o_done} !== 3'b000) begin n_bad++; $display("FAIL midrst_status: got %b need 000", {s_axis_tready, o_busy, o_done}); end
        n_cmp++; if (o_sym_count !== 8'd0) begin n_bad++; $display("FAIL midrst_symcnt: got %0d need 0", o_sym_count); end
        @(negedge aclk); #1;
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b need 0", o_done); end
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk);
        build_exp(4, 1, 5, 2);
        run_frame(4, 1, 5, 2, 80, 80, -1, -1, 200);
        errs = stream_errs(first);
        n_cmp++; if (errs !== 0 || got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL postrst_stream: %0d bad, got %0d beats need %0d", errs, got_q.size(), exp_q.size()); end
        n_cmp++; if (o_sym_count !== 8'd2) begin n_bad++; $display("FAIL postrst_symcnt: got %0d need 2", o_sym_count); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_small_offset();
        test_backpressure();
        test_degenerate();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_remover.md
# ofdm_cp_remover

Receive-side OFDM symbol framer: it is the counterpart of the transmit path that builds cyclic-prefixed symbols ahead of the DUC. It sits between the DDC output stream (packed I/Q, 100 MHz `aclk` domain) and the receive FFT. After a start command it drops a programmable timing offset. For each symbol it then discards the cyclic prefix and forwards exactly `nfft` samples, marking symbol boundaries with `tuser`/`tlast`.

## Interface
- `DATA_W`, 32: sample width; I in [15:0], Q in [31:16], passed unmodified.
- `NFFT_W`, 13: width of `i_nfft`; 4096 is the maximum used.
- `CP_W`, 11: width of `i_cp_len`.
- `SKIP_W`, 16: width of `i_skip`.
- `SYM_W`, 8: width of `i_num_symbols` and `o_sym_count`.

Ports:
- `aclk`, in, 1: clock.
- `areset`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: one-cycle pulse; arms a capture.
- `i_nfft`, in, NFFT_W: samples forwarded per symbol.
- `i_cp_len`, in, CP_W: samples discarded per symbol.
- `i_skip`, in, SKIP_W: samples discarded once, before the first CP.
- `i_num_symbols`, in, SYM_W: number of symbols per capture.
- `s_axis_tdata`, in, DATA_W: input data from the DDC.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready.
- `m_axis_tdata`, out, DATA_W: output data to the FFT.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: output ready.
- `m_axis_tlast`, out, 1: last sample of a symbol.
- `m_axis_tuser`, out, 1: first sample of a symbol.
- `o_busy`, out, 1: high from start acceptance until `o_done`.
- `o_done`, out, 1: one-cycle pulse when the capture completes.
- `o_sym_count`, out, SYM_W: symbols fully delivered in the current capture.

## Operation
- Configuration inputs are latched on an accepted `i_start`. Changes to them afterwards have no effect until the next capture.
- States:
  - IDLE: `s_axis_tready`=1 and incoming beats are dropped.
  - An accepted `i_start` goes to SKIP, or to CP if `i_skip`=0.
  - If `i_nfft`=0 or `i_num_symbols`=0, `i_start` instead goes directly to DONE.
- SKIP: drops `skip` accepted beats (`s_axis_tready`=1), then goes to CP.
- CP: drops `cp_len` accepted beats, then goes to DATA. With `cp_len`=0, CP is bypassed: the transition goes directly to DATA.
- DATA:
  - Forwards `nfft` beats with `tuser` on beat 0 and `tlast` on beat `nfft`-1.
  - After the last beat is accepted into the output stage: go to CP if symbols remain, else go to DRAIN.
- DRAIN: waits until the output stage is empty, then goes to DONE.
- DONE: one cycle; `o_done`=1; returns to IDLE.
- A beat is consumed only when `s_axis_tvalid && s_axis_tready`. All counters advance only on consumed beats.
- `i_start` is ignored outside IDLE.
- `o_sym_count` increments when a `tlast` beat is accepted downstream (`m_axis_tvalid && m_axis_tready && m_axis_tlast`). It is cleared on an accepted start.

## Timing
- Reset values: state IDLE; `s_axis_tready`=0 while `areset` is asserted, then 1 in IDLE; `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0; `o_busy`=0; `o_done`=0; `o_sym_count`=0.
- `o_busy` rises the cycle after `i_start` is accepted.
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`, through a 2-entry skid buffer.
- Throughput: 1 beat/cycle in all states when downstream is ready.
- Ready behaviour:
  - In SKIP and CP, `s_axis_tready`=1 regardless of `m_axis_tready`.
  - In DATA, `s_axis_tready` is the skid buffer's not-full flag, which is registered (no combinational path from `m_axis_tready`).
  - In DRAIN and DONE, `s_axis_tready`=0.
- Once `m_axis_tvalid` is asserted, it and `tdata`/`tlast`/`tuser` stay stable until accepted.
- `areset` mid-capture: everything returns to the reset values immediately and buffered beats are discarded. `o_done` is not pulsed.
- For `nfft`=1, beat 0 carries both `tuser` and `tlast`.

## Structure
- Shared package `ofdm_rx_pkg`:
  - State enum `cprm_state_t` (IDLE, SKIP, CP, DATA, DRAIN, DONE).
  - Defaults `NFFT_DEF`=4096 and `CP_DEF`=256.
  - I/Q field slice constants.
- Sub-module `axis_skid_buf`: parameterized width covering data+last+user, 2 entries, registered ready. It is reusable elsewhere in the RX chain.
- The top level holds the FSM, skip/CP/sample/symbol counters, and configuration latches.

## Test plan
- Nominal frame: `nfft`=4096, `cp`=256, `skip`=0, `num_symbols`=2, incrementing input data 0,1,2,…, `m_axis_tready`=1.
  - Output is 256..4351 then 4608..8703.
  - `tlast` on values 4351 and 8703; `tuser` on 256 and 4608.
  - `o_done` 1 cycle after the final acceptance; `o_sym_count`=2.
- Small frame with offset: `nfft`=8, `cp`=2, `skip`=3, 3 symbols.
  - Output is 5..12, 15..22, 25..32.
  - Beats 0..4 and 13,14 are dropped; `o_busy` deasserts with `o_done`.
- Backpressure: random `m_axis_tready` (50%) with random `s_axis_tvalid` gaps.
  - Same output sequence as the nominal frame, with no loss or duplication.
  - Output signals stay stable while stalled.
- Degenerate configurations:
  - `num_symbols`=0: `o_done` in the cycle after start, no output beats.
  - `cp`=0, `nfft`=1: every accepted beat is output with `tuser`=`tlast`=1.
- Control edges:
  - `i_start` during DATA is ignored and the counts are unchanged.
  - `areset` pulsed mid-symbol: outputs return to reset values; a following start yields a clean frame beginning at the new `skip`+`cp` offset.
